// File: rtl/motor_uart_pkg.sv
// Shared types and constants for the motor UART receive path.
// Pure definitions: no latency, no flow control.
package motor_uart_pkg;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    P_ADDR,
    P_CMD,
    P_DATA,
    P_CSUM
  } pkt_state_t;

  typedef struct packed {
    logic [6:0] cmd;
    logic [6:0] data;
  } motor_cmd_t;

  localparam logic [6:0] CSUM_MASK = 7'h7F;
  localparam int         PKT_LEN   = 4;

  // The checksum is always the final byte of a packet.
  localparam pkt_state_t P_LAST = pkt_state_t'(PKT_LEN - 1);

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling; byte_vld/frame_err ~9.5 bit times after start edge.
// No backpressure: byte_vld is a single-cycle strobe the consumer must take.
module uart_rx_byte
  import motor_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       frame_err
);

  localparam int               CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int               CNT_W    = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);

  logic             rx_meta, rx_sync, rx_prev;
  byte_state_t      state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_vld_d, frame_err_d;

  assign byte_dat = shreg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state_q   <= B_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      byte_vld  <= byte_vld_d;
      frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      B_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev && !rx_sync) begin
          state_d   = B_START;
          bit_cnt_d = '0;
        end
      end
      B_START: begin
        // A start bit that is high again at mid-bit was line noise.
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          state_d   = rx_sync ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_sync, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = B_STOP;
        end
      end
      B_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d   = '0;
          state_d     = B_IDLE;
          byte_vld_d  = rx_sync;
          frame_err_d = !rx_sync;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

endmodule

// File: rtl/motor_uart_rx.sv
// Reassembles 4-byte motor packets; cmd_valid/checksum_err one cycle after the checksum byte.
// No backpressure: strobes are single-cycle, cmd/data hold until the next good packet.
module motor_uart_rx
  import motor_uart_pkg::*;
#(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD         = 9600,
  parameter logic [7:0] ADDRESS      = 8'd128,
  parameter int         TIMEOUT_CLKS = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       cmd_valid,
  output logic [6:0] cmd,
  output logic [6:0] data,
  output logic       checksum_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int            TO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CLKS);

  logic            byte_vld;
  logic [7:0]      byte_dat;
  pkt_state_t      pkt_q, pkt_d;
  motor_cmd_t      buf_q, buf_d, out_q, out_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            cmd_valid_d, csum_err_d;
  logic [8:0]      sum;
  logic [6:0]      csum_exp;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byte (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_vld  (byte_vld),
    .byte_dat  (byte_dat),
    .frame_err (frame_err)
  );

  assign sum      = {1'b0, ADDRESS} + {2'b00, buf_q.cmd} + {2'b00, buf_q.data};
  assign csum_exp = 7'(sum & {2'b00, CSUM_MASK});
  assign busy     = (pkt_q != P_ADDR);
  assign cmd      = out_q.cmd;
  assign data     = out_q.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q        <= P_ADDR;
      buf_q        <= '0;
      out_q        <= '0;
      to_q         <= '0;
      cmd_valid    <= 1'b0;
      checksum_err <= 1'b0;
    end else begin
      pkt_q        <= pkt_d;
      buf_q        <= buf_d;
      out_q        <= out_d;
      to_q         <= to_d;
      cmd_valid    <= cmd_valid_d;
      checksum_err <= csum_err_d;
    end
  end

  always_comb begin
    pkt_d       = pkt_q;
    buf_d       = buf_q;
    out_d       = out_q;
    cmd_valid_d = 1'b0;
    csum_err_d  = 1'b0;

    if (!busy || byte_vld) to_d = '0;
    else if (to_q != TO_MAX) to_d = to_q + 1'b1;
    else to_d = to_q;

    if (byte_vld) begin
      // Any byte with bit7 set is a potential address: resync on it.
      if (!busy || byte_dat[7]) begin
        pkt_d = (byte_dat == ADDRESS) ? P_CMD : P_ADDR;
      end else begin
        case (pkt_q)
          P_CMD: begin
            buf_d.cmd = byte_dat[6:0];
            pkt_d     = P_DATA;
          end
          P_DATA: begin
            buf_d.data = byte_dat[6:0];
            pkt_d      = P_LAST;
          end
          P_LAST: begin
            if (byte_dat[6:0] == csum_exp) begin
              out_d       = buf_q;
              cmd_valid_d = 1'b1;
            end else begin
              csum_err_d = 1'b1;
            end
            pkt_d = P_ADDR;
          end
          default: pkt_d = P_ADDR;
        endcase
      end
    end else if (busy && (frame_err || to_q == TO_MAX)) begin
      pkt_d = P_ADDR;
    end
  end

endmodule

// File: tb/tb_motor_uart_rx.sv
// Directed + randomized packet stimulus against a byte-level packet reference model.
module tb_motor_uart_rx;

  localparam int         CLK_FREQ = 1_000_000;
  localparam int         BAUD     = 100_000;
  localparam int         CPB      = CLK_FREQ / BAUD;
  localparam int         TIMEOUT  = 300;
  localparam logic [7:0] ADDR     = 8'd128;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       cmd_valid;
  logic [6:0] cmd;
  logic [6:0] data;
  logic       checksum_err;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  motor_uart_rx #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .ADDRESS      (ADDR),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .data         (data),
    .checksum_err (checksum_err),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Observed strobe activity.
  int         cnt_valid = 0, cnt_csum = 0, cnt_frame = 0, mutex_viol = 0;
  logic [6:0] cap_cmd = '0, cap_data = '0;
  bit         busy_seen = 1'b0;

  // Reference model: packet position and expected strobe history.
  int m_state = 0, m_cmd = 0, m_data = 0;
  int m_ocmd = 0, m_odata = 0, m_lcmd = 0, m_ldata = 0;
  int exp_valid = 0, exp_csum = 0, exp_frame = 0;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      cnt_valid++;
      cap_cmd  = cmd;
      cap_data = data;
    end
    if (checksum_err === 1'b1) cnt_csum++;
    if (frame_err === 1'b1) cnt_frame++;
    if (int'(cmd_valid) + int'(checksum_err) + int'(frame_err) > 1) mutex_viol++;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input int b);
    if (m_state == 0 || b >= 128) begin
      m_state = (b == int'(ADDR)) ? 1 : 0;
    end else if (m_state == 1) begin
      m_cmd   = b;
      m_state = 2;
    end else if (m_state == 2) begin
      m_data  = b;
      m_state = 3;
    end else begin
      if ((int'(ADDR) + m_cmd + m_data) % 128 == b) begin
        exp_valid++;
        m_ocmd  = m_cmd;
        m_odata = m_data;
        m_lcmd  = m_cmd;
        m_ldata = m_data;
      end else begin
        exp_csum++;
      end
      m_state = 0;
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ocmd  = 0;
    m_odata = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] b, input bit stop_ok, input int idle);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick(idle);
  endtask

  task automatic xfer(input int b, input bit stop_ok);
    send_raw(8'(b), stop_ok, $urandom_range(2, 10));
    if (stop_ok) model_byte(b);
    else begin
      exp_frame++;
      m_state = 0;
    end
  endtask

  task automatic pkt(input int a, input int c, input int d, input int s);
    xfer(a, 1'b1);
    xfer(c, 1'b1);
    xfer(d, 1'b1);
    xfer(s, 1'b1);
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    chk({tag, "/cmd_valid_count"}, cnt_valid, exp_valid);
    chk({tag, "/checksum_err_count"}, cnt_csum, exp_csum);
    chk({tag, "/frame_err_count"}, cnt_frame, exp_frame);
    chk({tag, "/cmd"}, 32'(cmd), m_ocmd);
    chk({tag, "/data"}, 32'(data), m_odata);
    chk({tag, "/strobe_cmd"}, 32'(cap_cmd), m_lcmd);
    chk({tag, "/strobe_data"}, 32'(cap_data), m_ldata);
    chk({tag, "/busy"}, 32'(busy), 32'(m_state != 0));
    chk({tag, "/strobe_overlap"}, mutex_viol, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "/cmd_valid"}, 32'(cmd_valid), 0);
    chk({tag, "/cmd"}, 32'(cmd), 0);
    chk({tag, "/data"}, 32'(data), 0);
    chk({tag, "/checksum_err"}, 32'(checksum_err), 0);
    chk({tag, "/frame_err"}, 32'(frame_err), 0);
    chk({tag, "/busy"}, 32'(busy), 0);
  endtask

  initial begin
    int kind, c, d, s, f0, v0;

    rx    = 1'b1;
    reset = 1'b1;
    tick(3);
    check_reset_outputs("por");
    reset = 1'b0;
    model_reset();
    tick(5);

    // Basic packet, then the same with a corrupt checksum.
    pkt(8'h80, 8'h00, 8'h40, 8'h40);
    check_all("good_pkt");
    pkt(8'h80, 8'h00, 8'h40, 8'h41);
    check_all("bad_csum");

    // Foreign address must never make the receiver busy.
    busy_seen = 1'b0;
    pkt(8'h81, 8'h05, 8'h06, 8'h0B);
    chk("foreign_addr/busy_seen", 32'(busy_seen), 0);
    check_all("foreign_addr");
    pkt(8'h80, 8'h04, 8'h20, 8'h24);
    check_all("after_foreign");

    // Stop bit low on the data byte aborts the packet.
    xfer(8'h80, 1'b1);
    xfer(8'h05, 1'b1);
    xfer(8'h10, 1'b0);
    check_all("frame_abort");
    pkt(8'h80, 8'h06, 8'h07, 8'h0D);
    check_all("after_frame");

    // Short low glitch on an idle line.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check_all("glitch");
    pkt(8'h80, 8'h11, 8'h22, 8'h33);
    check_all("after_glitch");

    // Inter-byte timeout.
    xfer(8'h80, 1'b1);
    xfer(8'h00, 1'b1);
    tick(TIMEOUT / 2);
    check_all("timeout_pending");
    tick(TIMEOUT);
    m_state = 0;
    check_all("timeout_expired");
    xfer(8'h40, 1'b1);
    xfer(8'h40, 1'b1);
    check_all("timeout_tail");

    // Reset in the middle of a packet.
    pkt(8'h80, 8'h04, 8'h20, 8'h24);
    check_all("pre_reset");
    xfer(8'h80, 1'b1);
    xfer(8'h00, 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    check_reset_outputs("mid_reset");
    pkt(8'h80, 8'h01, 8'h02, 8'h03);
    check_all("after_reset");

    // Randomized packets: good, bad checksum, foreign address, mid-packet resync.
    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(0, 3);
      c    = $urandom_range(0, 127);
      d    = $urandom_range(0, 127);
      s    = (int'(ADDR) + c + d) % 128;
      case (kind)
        1: pkt(int'(ADDR), c, d, (s + $urandom_range(1, 127)) % 128);
        2: pkt($urandom_range(129, 255), c, d, s);
        3: begin
          xfer(int'(ADDR), 1'b1);
          xfer($urandom_range(0, 127), 1'b1);
          pkt(int'(ADDR), c, d, s);
        end
        default: pkt(int'(ADDR), c, d, s);
      endcase
      check_all($sformatf("rand%0d_kind%0d", k, kind));
    end

    // Line held low across reset release: at most one frame error, never a command.
    f0 = cnt_frame;
    v0 = cnt_valid;
    rx = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(150);
    rx = 1'b1;
    tick(20);
    @(negedge clk);
    chk("low_at_reset/frame_err_le1", 32'((cnt_frame - f0) <= 1), 1);
    chk("low_at_reset/cmd_valid", cnt_valid - v0, 0);
    chk("low_at_reset/busy", 32'(busy), 0);
    chk("low_at_reset/cmd", 32'(cmd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
